jt10_snd_mix: RTL and testbench
===============================

# jt10_snd_mix

Parametrised per-channel sound mixer for the YM2610/YM2612 family cores. Takes NCH signed channel samples (FM channels, ADPCM-A/B, PSG), applies a per-channel unsigned gain and left/right pan, and accumulates them serially, one channel per `cen` cycle, into saturated stereo outputs. It sits between the synthesis cores and the audio output. Unlike a fixed mix, channel count, widths and gain precision are parameters, and gains and pans are run-time writable.

## Interface
Parameters:
- `NCH`, 6: channel count, 2..16.
- `WI`, 16: signed input sample width.
- `WO`, 16: signed output width, with WO ≤ WI+GW.
- `GW`, 8: unsigned gain width.
- `FRAC`, 4: gain fraction bits. Unity gain is `1<<FRAC`.
- `AW`, `$clog2(NCH)`: gain address width.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `cen`  in  1: clock enable. All sequencing advances only when `cen`=1.
- `ch_in`  in  NCH*WI: packed signed samples. Channel k is at bits [k*WI +: WI].
- `ch_en`  in  NCH: per-channel enable. A disabled channel contributes 0.
- `sample_in`  in  1: strobe marking `ch_in` valid. Sampled when `cen`=1.
- `gain_we`  in  1: gain/pan write strobe, sampled on `clk` and independent of `cen`.
- `gain_addr`  in  AW: channel index. Writes with index ≥ NCH are ignored.
- `gain_din`  in  GW: gain value.
- `pan_din`  in  2: pan bits. Bit1 = left, bit0 = right.
- `snd_left`, `snd_right`  out  WO: signed mixed output.
- `snd_sample`  out  1: one-`clk` pulse when the outputs update.
- `busy`  out  1: accumulation in progress.
- `sat_l`, `sat_r`  out  1: the last output on that side was clipped.
- `overrun`  out  1: sticky. Set when `sample_in` arrives while busy. Cleared only by reset.

## Operation
- Reset state: every gain = `1<<FRAC`, every pan = 2'b11. All outputs 0. FSM in IDLE. No write pending.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - On `cen & sample_in`: snapshot `ch_in` and `ch_en`, clear both accumulators, set channel counter to 0, go to ACC.
  - `busy` goes high on the same edge.
- ACC: on each `cen`, process channel `cnt`:
  - product = `$signed(in_k) * $signed({1'b0,gain_k})`, width WI+GW+1.
  - If `ch_en_k` and pan bit1 are set, add product to `acc_l`. If `ch_en_k` and pan bit0 are set, add product to `acc_r`.
  - Accumulator width is WI+GW+1+AW, so it never overflows.
  - After channel NCH-1, go to DONE.
- DONE: on the next `cen`:
  - Arithmetic shift each accumulator right by FRAC (floor; no rounding).
  - Saturate to [-2^(WO-1), 2^(WO-1)-1]. Set `sat_x` if clipping occurred, clear it otherwise.
  - Register `snd_left` / `snd_right`, pulse `snd_sample`, drop `busy`, return to IDLE.
- `sample_in` while in ACC or DONE: ignored and `overrun` set. The snapshot is not disturbed.
- Gain/pan writes:
  - In IDLE: applied to the table on the next `clk` edge.
  - In ACC or DONE: stored in a one-entry pending buffer. The last write wins. The buffer is applied on the edge that enters IDLE, so gains never change mid-sample.
  - If a write coincides with that IDLE-entry edge, the new write wins over the pending one.
- Reset mid-accumulation: the sample is abandoned. Outputs return to 0 and the pending write is discarded.
- Outputs hold their value between updates.

## Timing
- Latency from the `cen` edge accepting `sample_in` to the `snd_sample` edge: NCH+1 `cen` cycles. This is 7 for NCH=6.
- Minimum sample period: NCH+2 `cen` cycles. A strobe on the `cen` cycle right after DONE is accepted.
- `snd_sample` is high for exactly one `clk` cycle, regardless of `cen`.
- `busy` is high from the accept edge through the DONE edge inclusive of ACC. It is low in the same cycle `snd_sample` is high.
- Gain write in IDLE: visible to a sample accepted on the following `cen` edge or later.

## Structure
- Shared package (`jt10_mix_pkg`) holds:
  - FSM state encoding: IDLE=0, ACC=1, DONE=2.
  - Unity-gain constant function `1<<FRAC`.
  - Saturation helper function.
- Sub-module `jt10_mix_sat` contains the parametrised shift-and-clip stage, instantiated twice (left and right).
- Gain/pan table is a flat register array (NCH × (GW+2)) inside the top level. No RAM inference is required.

## Test plan
Defaults: NCH=6, WI=16, GW=8, FRAC=4.
- After reset, all `ch_in`=0x1000 with `ch_en`=6'h3F and one `sample_in` → after 7 `cen`: `snd_left` = `snd_right` = 0x6000, `snd_sample` is a single pulse, `sat_l` = `sat_r` = 0.
- All `ch_in`=0x7FFF → outputs 0x7FFF with `sat_l` = `sat_r` = 1. All `ch_in`=0x8000 → outputs 0x8000 with both sat flags set.
- Write ch0 gain=0x08, pan=2'b10. Only ch0 enabled, `ch_in[0]`=0x4000 → `snd_left`=0x2000, `snd_right`=0.
- Write ch1 gain=0x00 during ACC. The current sample uses the old gain 0x10; the next sample uses 0. Check both. A second write during the same ACC overrides the first.
- `sample_in` asserted 3 `cen` cycles after accept → ignored and `overrun`=1 (sticky). The result equals the first sample.
- Assert `rst` mid-ACC → outputs 0, `busy`=0, gains back to 0x10. The next sample mixes normally.

Source files
------------

// File: rtl/jt10_mix_pkg.sv
// Shared types and helpers for the serial stereo sound mixer.
// Holds the FSM encoding, the unity-gain constant and the clip helper.
package jt10_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } mix_state_t;

  function automatic int unsigned unity_gain(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  // Clamp a sign-extended value into the range of a wo-bit signed word.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                   input int unsigned wo);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wo - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wo - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/jt10_mix_sat.sv
// Shift-and-clip stage: floors the accumulator by FRAC bits and saturates to WO bits.
// Purely combinational; the caller registers dout and clip.
module jt10_mix_sat
  import jt10_mix_pkg::*;
#(
  parameter int WA   = 28,
  parameter int WO   = 16,
  parameter int FRAC = 4
) (
  input  logic signed [WA-1:0] acc,
  output logic signed [WO-1:0] dout,
  output logic                 clip
);

  logic signed [WA-1:0] shifted;
  logic signed [63:0]   wide;
  logic signed [63:0]   clipped;

  always_comb begin
    shifted = acc >>> FRAC;
    wide    = 64'(shifted);
    clipped = sat_clip(wide, WO);
    dout    = clipped[WO-1:0];
    clip    = (clipped != wide);
  end

endmodule

// File: rtl/jt10_snd_mix.sv
// Serial stereo mixer: one channel per cen through gain/pan into wide accumulators.
// Result appears NCH+1 cen cycles after the accepting strobe; gain writes while busy are deferred.
module jt10_snd_mix
  import jt10_mix_pkg::*;
#(
  parameter int NCH  = 6,
  parameter int WI   = 16,
  parameter int WO   = 16,
  parameter int GW   = 8,
  parameter int FRAC = 4,
  parameter int AW   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic [NCH*WI-1:0]    ch_in,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 sample_in,
  input  logic                 gain_we,
  input  logic [AW-1:0]        gain_addr,
  input  logic [GW-1:0]        gain_din,
  input  logic [1:0]           pan_din,
  output logic signed [WO-1:0] snd_left,
  output logic signed [WO-1:0] snd_right,
  output logic                 snd_sample,
  output logic                 busy,
  output logic                 sat_l,
  output logic                 sat_r,
  output logic                 overrun
);

  localparam int WP = WI + GW + 1;
  localparam int WA = WP + AW;
  localparam logic [GW-1:0] UNITY = GW'(unity_gain(FRAC));

  mix_state_t state, state_nxt;

  logic [AW-1:0]        cnt;
  logic signed [WI-1:0] snap_smp [NCH];
  logic [NCH-1:0]       snap_en;

  logic [GW-1:0]        gain_tbl [NCH];
  logic [1:0]           pan_tbl  [NCH];

  logic                 pend_vld;
  logic [AW-1:0]        pend_addr;
  logic [GW-1:0]        pend_gain;
  logic [1:0]           pend_pan;

  logic signed [WA-1:0] acc_l;
  logic signed [WA-1:0] acc_r;
  logic signed [WP-1:0] prod;

  logic                 wr_ok;
  logic                 accept;
  logic                 last_ch;
  logic                 to_idle;

  logic signed [WO-1:0] mix_l;
  logic signed [WO-1:0] mix_r;
  logic                 clip_l;
  logic                 clip_r;

  assign wr_ok   = gain_we && (int'(gain_addr) < NCH);
  assign accept  = cen && sample_in && (state == ST_IDLE);
  assign last_ch = (int'(cnt) == NCH - 1);
  assign to_idle = cen && (state == ST_DONE);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cen) begin
      case (state)
        ST_IDLE: if (sample_in) state_nxt = ST_ACC;
        ST_ACC:  if (last_ch)   state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Gain is zero-extended so the multiply stays signed without reinterpreting its MSB.
  always_comb begin
    prod = WP'(snap_smp[cnt]) * WP'($signed({1'b0, gain_tbl[cnt]}));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      snap_en    <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      snd_left   <= '0;
      snd_right  <= '0;
      snd_sample <= 1'b0;
      sat_l      <= 1'b0;
      sat_r      <= 1'b0;
      overrun    <= 1'b0;
      for (int k = 0; k < NCH; k++) snap_smp[k] <= '0;
    end else begin
      snd_sample <= 1'b0;
      if (accept) begin
        for (int k = 0; k < NCH; k++) snap_smp[k] <= ch_in[k*WI +: WI];
        snap_en <= ch_en;
        acc_l   <= '0;
        acc_r   <= '0;
        cnt     <= '0;
      end
      if (cen && sample_in && (state != ST_IDLE)) overrun <= 1'b1;
      if (cen && (state == ST_ACC)) begin
        if (snap_en[cnt] && pan_tbl[cnt][1]) acc_l <= acc_l + WA'(prod);
        if (snap_en[cnt] && pan_tbl[cnt][0]) acc_r <= acc_r + WA'(prod);
        cnt <= last_ch ? '0 : cnt + AW'(1);
      end
      if (to_idle) begin
        snd_left   <= mix_l;
        snd_right  <= mix_r;
        sat_l      <= clip_l;
        sat_r      <= clip_r;
        snd_sample <= 1'b1;
      end
    end
  end

  // Writes landing mid-sample are parked and committed on the edge back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_gain <= '0;
      pend_pan  <= '0;
      for (int k = 0; k < NCH; k++) begin
        gain_tbl[k] <= UNITY;
        pan_tbl[k]  <= 2'b11;
      end
    end else if (state == ST_IDLE) begin
      if (wr_ok) begin
        gain_tbl[gain_addr] <= gain_din;
        pan_tbl[gain_addr]  <= pan_din;
      end
    end else if (to_idle) begin
      pend_vld <= 1'b0;
      if (wr_ok) begin
        gain_tbl[gain_addr] <= gain_din;
        pan_tbl[gain_addr]  <= pan_din;
      end else if (pend_vld) begin
        gain_tbl[pend_addr] <= pend_gain;
        pan_tbl[pend_addr]  <= pend_pan;
      end
    end else if (wr_ok) begin
      pend_vld  <= 1'b1;
      pend_addr <= gain_addr;
      pend_gain <= gain_din;
      pend_pan  <= pan_din;
    end
  end

  jt10_mix_sat #(.WA(WA), .WO(WO), .FRAC(FRAC)) u_sat_l (
    .acc  (acc_l),
    .dout (mix_l),
    .clip (clip_l)
  );

  jt10_mix_sat #(.WA(WA), .WO(WO), .FRAC(FRAC)) u_sat_r (
    .acc  (acc_r),
    .dout (mix_r),
    .clip (clip_r)
  );

endmodule

// File: tb/tb_jt10_snd_mix.sv
// Scoreboard bench for jt10_snd_mix: an arithmetic mixing model predicts each output sample.
module tb_jt10_snd_mix;
  localparam int NCH  = 6;
  localparam int WI   = 16;
  localparam int WO   = 16;
  localparam int GW   = 8;
  localparam int FRAC = 4;
  localparam int AW   = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cen = 1'b0;
  logic [NCH*WI-1:0]    ch_in = '0;
  logic [NCH-1:0]       ch_en = '0;
  logic                 sample_in = 1'b0;
  logic                 gain_we = 1'b0;
  logic [AW-1:0]        gain_addr = '0;
  logic [GW-1:0]        gain_din = '0;
  logic [1:0]           pan_din = '0;
  logic signed [WO-1:0] snd_left;
  logic signed [WO-1:0] snd_right;
  logic                 snd_sample;
  logic                 busy;
  logic                 sat_l;
  logic                 sat_r;
  logic                 overrun;

  jt10_snd_mix #(.NCH(NCH), .WI(WI), .WO(WO), .GW(GW), .FRAC(FRAC), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .ch_in(ch_in), .ch_en(ch_en),
    .sample_in(sample_in), .gain_we(gain_we), .gain_addr(gain_addr),
    .gain_din(gain_din), .pan_din(pan_din), .snd_left(snd_left),
    .snd_right(snd_right), .snd_sample(snd_sample), .busy(busy),
    .sat_l(sat_l), .sat_r(sat_r), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint l;
    longint r;
    bit     sl;
    bit     sr;
    int     at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  int   cen_edges = 0;
  bit   inflight = 1'b0;
  int   done_edge = 0;
  bit   m_ovr = 1'b0;
  int   m_gain [NCH];
  int   m_pan  [NCH];
  bit   pend_vld = 1'b0;
  int   pend_a, pend_g, pend_p;
  logic [WI-1:0]  tb_in [NCH];
  logic [NCH-1:0] tb_en = '0;
  bit   prev_ss = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_gain[k] = 1 << FRAC;
      m_pan[k]  = 3;
    end
    pend_vld = 1'b0;
    inflight = 1'b0;
    m_ovr    = 1'b0;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic void clamp(input longint v, output longint o, output bit s);
    longint hi, lo;
    hi = (64'sd1 << (WO - 1)) - 1;
    lo = -(64'sd1 << (WO - 1));
    s = 1'b1;
    if (v > hi)      o = hi;
    else if (v < lo) o = lo;
    else begin o = v; s = 1'b0; end
  endfunction

  function automatic exp_t model_mix();
    longint al = 0, ar = 0, p;
    exp_t e;
    for (int k = 0; k < NCH; k++) begin
      if (tb_en[k]) begin
        p = longint'($signed(tb_in[k])) * longint'(m_gain[k]);
        if ((m_pan[k] & 2) != 0) al += p;
        if ((m_pan[k] & 1) != 0) ar += p;
      end
    end
    clamp(floor_div(al, 1 << FRAC), e.l, e.sl);
    clamp(floor_div(ar, 1 << FRAC), e.r, e.sr);
    e.at = 0;
    return e;
  endfunction

  // One cen cycle, preceded by a random number of clk cycles with cen low.
  task automatic tick(input bit smp);
    exp_t e;
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      cen = 1'b0; sample_in = 1'b0;
      @(posedge clk); #1;
    end
    for (int k = 0; k < NCH; k++) ch_in[k*WI +: WI] = tb_in[k];
    ch_en = tb_en;
    cen = 1'b1; sample_in = smp;
    @(posedge clk);
    cen_edges++;
    if (inflight) begin
      if (smp) m_ovr = 1'b1;
      if (cen_edges == done_edge) begin
        inflight = 1'b0;
        if (pend_vld) begin
          m_gain[pend_a] = pend_g;
          m_pan[pend_a]  = pend_p;
          pend_vld = 1'b0;
        end
      end
    end else if (smp) begin
      e = model_mix();
      e.at = cen_edges + NCH + 1;
      sb.push_back(e);
      inflight  = 1'b1;
      done_edge = e.at;
    end
    #1;
    cen = 1'b0; sample_in = 1'b0;
  endtask

  task automatic wr(input int a, input int g, input int p);
    cen = 1'b0;
    gain_we = 1'b1; gain_addr = AW'(a); gain_din = GW'(g); pan_din = 2'(p);
    @(posedge clk); #1;
    gain_we = 1'b0;
    if (a < NCH) begin
      if (inflight) begin
        pend_vld = 1'b1; pend_a = a; pend_g = g; pend_p = p;
      end else begin
        m_gain[a] = g; m_pan[a] = p;
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (inflight && guard < NCH + 4) begin
      tick(1'b0);
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("outputs_delivered", sb.size(), 0);
    chk("busy_after_sample", busy, 0);
    sb.delete();
  endtask

  task automatic set_all(input logic [WI-1:0] v, input logic [NCH-1:0] en);
    for (int k = 0; k < NCH; k++) tb_in[k] = v;
    tb_en = en;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_left"}, snd_left, 0);
    chk({tag, "_right"}, snd_right, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sample"}, snd_sample, 0);
    chk({tag, "_sat"}, {sat_l, sat_r}, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && snd_sample) begin
      chk("pulse_single_cycle", prev_ss, 0);
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_sample: got an output pulse, expected none");
      end else begin
        mon_e = sb.pop_front();
        chk("snd_left", snd_left, mon_e.l);
        chk("snd_right", snd_right, mon_e.r);
        chk("sat_l", sat_l, mon_e.sl);
        chk("sat_r", sat_r, mon_e.sr);
        chk("latency_cen", cen_edges, mon_e.at);
        chk("busy_at_pulse", busy, 0);
      end
    end
    prev_ss = snd_sample;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int act;
    model_reset();
    set_all(16'h0000, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("reset");

    // Unity gain, all channels
    set_all(16'h1000, 6'h3F);
    tick(1'b1);
    chk("busy_on_accept", busy, 1);
    drain();

    set_all(16'h7FFF, 6'h3F);
    tick(1'b1); drain();
    set_all(16'h8000, 6'h3F);
    tick(1'b1); drain();

    wr(0, 8'h08, 2'b10);
    set_all(16'h0000, 6'h01);
    tb_in[0] = 16'h4000;
    tick(1'b1); drain();

    // Deferred gain writes: old gain for this sample, last write for the next
    set_all(16'h1000, 6'h3F);
    tick(1'b1); tick(1'b0);
    wr(1, 8'h20, 2'b11);
    tick(1'b0);
    wr(1, 8'h00, 2'b11);
    drain();
    tick(1'b1); drain();

    chk("overrun_clear", overrun, 0);
    set_all(16'h0F00, 6'h3F);
    tick(1'b1); tick(1'b0); tick(1'b0);
    set_all(16'h7123, 6'h2A);
    tick(1'b1);
    drain();
    chk("overrun_set", overrun, 1);

    set_all(16'h1234, 6'h3F);
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    model_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midreset");
    set_all(16'h1000, 6'h3F);
    tick(1'b1); drain();

    for (int it = 0; it < 120; it++) begin
      act = $urandom_range(0, 9);
      for (int k = 0; k < NCH; k++) begin
        tb_in[k] = WI'($urandom());
        if ($urandom_range(0, 1) == 1) tb_in[k] = WI'($signed(tb_in[k]) >>> 4);
      end
      tb_en = NCH'($urandom());
      if (act < 3)
        wr($urandom_range(0, 7),
           ($urandom_range(0, 1) == 1) ? $urandom_range(0, 32) : $urandom_range(0, 255),
           $urandom_range(0, 3));
      else
        tick(act < 7);
    end
    drain();
    chk("overrun_random", overrun, m_ovr);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
